// File: rtl/alu_sequencer.sv
// alu_sequencer: 2-entry command FIFO feeding an external ALU with a fixed result latency,
// then holding the captured result until the consumer takes it.
module alu_sequencer #(
    parameter int WIDTH   = 20,
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_op1,
    input  logic [WIDTH-1:0] cmd_op2,
    input  logic [1:0]       cmd_operation,
    input  logic             cmd_sign,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    output logic [1:0]       alu_operation,
    output logic             alu_sign,
    input  logic [WIDTH-1:0] alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic [1:0]       rsp_operation,
    output logic             rsp_sign,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);
    localparam int EW = 2 * WIDTH + 3;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t        state_q;
    logic [3:0]    wait_q;
    logic [1:0]    cnt_q, cnt_d;
    logic [EW-1:0] head_q, head_d, tail_q, tail_d, cmd_ent;
    logic          push, pop;
    assign cmd_ent   = {cmd_op1, cmd_op2, cmd_operation, cmd_sign};
    assign cmd_ready = rst_n && cnt_q != 2'd2;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state_q == IDLE && cnt_q != 2'd0;
    assign busy      = cnt_q != 2'd0 || state_q != IDLE;
    // Head is always slot 0; a pop shifts the tail forward or takes a same-edge push directly.
    always_comb begin
        cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
        head_d = pop ? (cnt_q == 2'd2 ? tail_q : cmd_ent) : (push && cnt_q == 2'd0 ? cmd_ent : head_q);
        tail_d = push && !pop && cnt_q == 2'd1 ? cmd_ent : tail_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wait_q        <= '0;
            alu_op1       <= '0;
            alu_op2       <= '0;
            alu_operation <= '0;
            alu_sign      <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_result    <= '0;
            rsp_operation <= '0;
            rsp_sign      <= 1'b0;
            done_count    <= '0;
        end else begin
            case (state_q)
                IDLE: if (pop) begin
                    {alu_op1, alu_op2, alu_operation, alu_sign} <= head_q;
                    wait_q  <= 4'(ALU_LAT);
                    state_q <= WAIT;
                end
                WAIT: begin
                    wait_q <= wait_q - 4'd1;
                    if (wait_q == 4'd1) begin
                        rsp_result    <= alu_result;
                        rsp_operation <= alu_operation;
                        rsp_sign      <= alu_sign;
                        rsp_valid     <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: if (rsp_ready) begin
                    rsp_valid  <= 1'b0;
                    done_count <= done_count + 1'b1;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: two instances (ALU_LAT=1/CNT_W=2 and ALU_LAT=4/CNT_W=16) share stimulus;
// a timestamp/queue reference model predicts every output each cycle.
module tb_alu_sequencer;
    localparam int W = 20;
    typedef struct packed {bit [W-1:0] op1; bit [W-1:0] op2; bit [1:0] op; bit sign;} cmd_t;

    logic         clk = 0;
    logic         rst_n = 0;
    logic         cmd_valid = 0;
    logic         rsp_ready = 0;
    logic [W-1:0] cmd_op1 = '0;
    logic [W-1:0] cmd_op2 = '0;
    logic [1:0]   cmd_operation = '0;
    logic         cmd_sign = 0;
    logic         a_ready, a_rv, a_rs, a_asg, a_busy;
    logic [W-1:0] a_ao1, a_ao2, a_res, a_rr;
    logic [1:0]   a_aop, a_ro, a_dc;
    logic         b_ready, b_rv, b_rs, b_asg, b_busy;
    logic [W-1:0] b_ao1, b_ao2, b_res, b_rr;
    logic [1:0]   b_aop, b_ro;
    logic [15:0]  b_dc;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [W-1:0] alu_f(input cmd_t c);
        case (c.op)
            2'd0:    return c.op1 + c.op2;
            2'd1:    return c.op1 - c.op2;
            2'd2:    return c.op1 & c.op2;
            default: return c.op1 ^ c.op2;
        endcase
    endfunction

    assign a_res = alu_f({a_ao1, a_ao2, a_aop, a_asg});
    assign b_res = alu_f({b_ao1, b_ao2, b_aop, b_asg});

    alu_sequencer #(.WIDTH(W), .ALU_LAT(1), .CNT_W(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(a_ready),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_operation(cmd_operation), .cmd_sign(cmd_sign),
        .alu_op1(a_ao1), .alu_op2(a_ao2), .alu_operation(a_aop), .alu_sign(a_asg),
        .alu_result(a_res), .rsp_valid(a_rv), .rsp_ready(rsp_ready), .rsp_result(a_rr),
        .rsp_operation(a_ro), .rsp_sign(a_rs), .busy(a_busy), .done_count(a_dc)
    );

    alu_sequencer #(.WIDTH(W), .ALU_LAT(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(b_ready),
        .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_operation(cmd_operation), .cmd_sign(cmd_sign),
        .alu_op1(b_ao1), .alu_op2(b_ao2), .alu_operation(b_aop), .alu_sign(b_asg),
        .alu_result(b_res), .rsp_valid(b_rv), .rsp_ready(rsp_ready), .rsp_result(b_rr),
        .rsp_operation(b_ro), .rsp_sign(b_rs), .busy(b_busy), .done_count(b_dc)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Reference model: accepted/issued counts, issue timestamp and handshake count per instance.
    cmd_t hist [2][1024];
    cmd_t last [2];
    int   acc [2];
    int   iss [2];
    int   ie [2];
    int   done [2];
    bit   infl [2];
    int   cyc = 0;

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            acc[k]  = 0;
            iss[k]  = 0;
            ie[k]   = 0;
            done[k] = 0;
            infl[k] = 0;
            last[k] = '0;
        end
    endtask

    task automatic model_step(input int k, input int lat);
        int occ;
        bit was_valid;
        occ = acc[k] - iss[k];
        was_valid = infl[k] && cyc >= ie[k] + lat;
        if (!infl[k] && occ > 0) begin
            last[k] = hist[k][iss[k] % 1024];
            iss[k]++;
            infl[k] = 1;
            ie[k] = cyc + 1;
        end else if (was_valid && rsp_ready) begin
            infl[k] = 0;
            done[k]++;
        end
        if (cmd_valid && occ < 2) begin
            hist[k][acc[k] % 1024] = {cmd_op1, cmd_op2, cmd_operation, cmd_sign};
            acc[k]++;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_clear();
        else begin
            model_step(0, 1);
            model_step(1, 4);
            cyc++;
        end
    end

    task automatic verify(input string p, input int k, input int lat, input int cw,
                          input logic rdy, input logic vld, input logic bsy,
                          input logic [W-1:0] o1, input logic [W-1:0] o2, input logic [1:0] aop,
                          input logic asg, input logic [W-1:0] rr, input logic [1:0] ro,
                          input logic rs, input logic [15:0] dc);
        int occ;
        bit ev;
        occ = acc[k] - iss[k];
        ev = infl[k] && cyc >= ie[k] + lat;
        check({p, "_ready"}, 64'(rdy), 64'(rst_n && occ < 2));
        check({p, "_valid"}, 64'(vld), 64'(ev));
        check({p, "_busy"}, 64'(bsy), 64'(occ > 0 || infl[k]));
        check({p, "_alu_op1"}, 64'(o1), 64'(last[k].op1));
        check({p, "_alu_op2"}, 64'(o2), 64'(last[k].op2));
        check({p, "_alu_operation"}, 64'(aop), 64'(last[k].op));
        check({p, "_alu_sign"}, 64'(asg), 64'(last[k].sign));
        check({p, "_done"}, 64'(dc), 64'(done[k] % (1 << cw)));
        if (ev) begin
            check({p, "_rsp_result"}, 64'(rr), 64'(alu_f(last[k])));
            check({p, "_rsp_operation"}, 64'(ro), 64'(last[k].op));
            check({p, "_rsp_sign"}, 64'(rs), 64'(last[k].sign));
        end
    endtask

    always @(negedge clk) begin
        verify("A", 0, 1, 2, a_ready, a_rv, a_busy, a_ao1, a_ao2, a_aop, a_asg, a_rr, a_ro, a_rs, 16'(a_dc));
        verify("B", 1, 4, 16, b_ready, b_rv, b_busy, b_ao1, b_ao2, b_aop, b_asg, b_rr, b_ro, b_rs, b_dc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input cmd_t c);
        cmd_valid     = 1;
        cmd_op1       = c.op1;
        cmd_op2       = c.op2;
        cmd_operation = c.op;
        cmd_sign      = c.sign;
    endtask

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c.op1  = W'($urandom);
        c.op2  = W'($urandom);
        c.op   = 2'($urandom);
        c.sign = 1'($urandom);
        return c;
    endfunction

    task automatic wait_a_valid(input int bound);
        for (int i = 0; i < bound && !a_rv; i++) tick();
        check("A_wait_valid", 64'(a_rv), 64'd1);
    endtask

    initial begin
        cmd_t c;
        cmd_t bp [3];
        rst_n = 0;
        repeat (3) tick();
        check("A_rst_ready", 64'(a_ready), 64'd0);
        check("B_rst_busy", 64'(b_busy), 64'd0);
        check("A_rst_done", 64'(a_dc), 64'd0);
        rst_n = 1;
        #1;
        check("A_ready_after_rst", 64'(a_ready), 64'd1);
        check("B_ready_after_rst", 64'(b_ready), 64'd1);

        rsp_ready = 1;
        c = '{20'd5, 20'd3, 2'd0, 1'b0};
        send(c);
        tick();
        cmd_valid = 0;
        tick();
        check("A_single_alu_op1", 64'(a_ao1), 64'd5);
        check("A_single_alu_op2", 64'(a_ao2), 64'd3);
        check("A_single_early", 64'(a_rv), 64'd0);
        tick();
        check("A_single_valid", 64'(a_rv), 64'd1);
        check("A_single_result", 64'(a_rr), 64'd8);
        check("A_single_op", 64'(a_ro), 64'd0);
        repeat (3) tick();
        check("B_single_valid", 64'(b_rv), 64'd1);
        check("B_single_result", 64'(b_rr), 64'd8);
        repeat (4) tick();

        c = '{20'hFFFFF, 20'd1, 2'd1, 1'b0};
        send(c);
        tick();
        cmd_valid = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            check("B_lat_valid", 64'(b_rv), 64'(i == 5));
        end
        check("B_lat_result", 64'(b_rr), 64'hFFFFE);
        check("B_lat_model", 64'(b_rr), 64'(alu_f(c)));
        repeat (4) tick();

        bp[0] = rnd_cmd();
        bp[1] = rnd_cmd();
        send(bp[0]);
        tick();
        send(bp[1]);
        tick();
        cmd_valid = 0;
        check("A_pp_alu", 64'(a_ao1), 64'(bp[0].op1));
        check("A_pp_busy", 64'(a_busy), 64'd1);
        check("A_pp_ready", 64'(a_ready), 64'd1);
        repeat (3) tick();
        check("A_pp_next", 64'(a_ao1), 64'(bp[1].op1));
        repeat (20) tick();

        rst_n = 0;
        tick();
        rst_n = 1;
        rsp_ready = 0;
        c = rnd_cmd();
        for (int i = 0; i < 3; i++) bp[i] = rnd_cmd();
        send(c);
        tick();
        cmd_valid = 0;
        wait_a_valid(10);
        send(bp[0]);
        tick();
        send(bp[1]);
        tick();
        send(bp[2]);
        check("A_bp_full", 64'(a_ready), 64'd0);
        check("B_bp_full", 64'(b_ready), 64'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("A_bp_ready", 64'(a_ready), 64'd0);
            check("A_bp_valid", 64'(a_rv), 64'd1);
            check("A_bp_hold", 64'(a_rr), 64'(alu_f(c)));
        end
        cmd_valid = 0;
        rsp_ready = 1;
        wait_a_valid(10);
        check("A_bp_first", 64'(a_rr), 64'(alu_f(c)));
        tick();
        for (int i = 0; i < 2; i++) begin
            wait_a_valid(10);
            check("A_bp_order", 64'(a_rr), 64'(alu_f(bp[i])));
            tick();
        end
        check("A_bp_done", 64'(a_dc), 64'd3);
        repeat (25) tick();
        check("B_bp_done", 64'(b_dc), 64'd3);

        for (int i = 0; i < 3; i++) begin
            send(rnd_cmd());
            tick();
        end
        cmd_valid = 0;
        check("B_mw_busy", 64'(b_busy), 64'd1);
        check("A_mw_valid_pre", 64'(a_rv), 64'd1);
        rst_n = 0;
        #1;
        check("A_mw_valid", 64'(a_rv), 64'd0);
        check("B_mw_valid", 64'(b_rv), 64'd0);
        check("B_mw_alu_op1", 64'(b_ao1), 64'd0);
        check("B_mw_alu_op2", 64'(b_ao2), 64'd0);
        check("A_mw_alu_op1", 64'(a_ao1), 64'd0);
        check("A_mw_result", 64'(a_rr), 64'd0);
        check("B_mw_busy_rst", 64'(b_busy), 64'd0);
        check("B_mw_ready_rst", 64'(b_ready), 64'd0);
        tick();
        tick();
        rst_n = 1;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("A_mw_no_rsp", 64'(a_rv), 64'd0);
            check("B_mw_no_rsp", 64'(b_rv), 64'd0);
        end
        check("A_mw_done", 64'(a_dc), 64'd0);
        check("B_mw_done", 64'(b_dc), 64'd0);

        for (int i = 0; i < 5; i++) begin
            send(rnd_cmd());
            tick();
            cmd_valid = 0;
            wait_a_valid(10);
            tick();
            check("A_wrap", 64'(a_dc), 64'((i + 1) % 4));
        end

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0) send(rnd_cmd());
            else cmd_valid = 0;
            rsp_ready = $urandom_range(0, 3) != 0;
            rst_n = $urandom_range(0, 299) != 0;
            tick();
        end
        rst_n = 1;
        cmd_valid = 0;
        repeat (5) tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
